// File: rtl/syn_fifo_ext_module_if.sv
// Handshake/data bundle between a producer/consumer pair and syn_fifo_ext_module.
// Signal names keep the original FIFO port names, seen from the FIFO side.
interface syn_fifo_ext_module_if #(
  parameter int unsigned P_DATA_WIDTH = 8,
  parameter int unsigned P_ADDR_DEPTH = 16
);
  localparam int unsigned CW = $clog2(P_ADDR_DEPTH) + 1;

  logic                    i_wr_en;
  logic [P_DATA_WIDTH-1:0] i_wdata;
  logic                    o_wfull;
  logic                    o_almost_full;
  logic                    o_overflow;
  logic                    i_rd_en;
  logic [P_DATA_WIDTH-1:0] o_rdata;
  logic                    o_rvalid;
  logic                    o_rempty;
  logic                    o_almost_empty;
  logic                    o_underflow;
  logic [CW-1:0]           o_data_count;

  // Producer/consumer side
  modport master (
    output i_wr_en, i_wdata, i_rd_en,
    input  o_wfull, o_almost_full, o_overflow,
    input  o_rdata, o_rvalid, o_rempty, o_almost_empty, o_underflow, o_data_count
  );

  // FIFO side
  modport slave (
    input  i_wr_en, i_wdata, i_rd_en,
    output o_wfull, o_almost_full, o_overflow,
    output o_rdata, o_rvalid, o_rempty, o_almost_empty, o_underflow, o_data_count
  );
endinterface

// File: rtl/syn_fifo_ext_module.sv
// Single-clock synchronous FIFO with standard or first-word-fall-through read,
// occupancy count, almost-full/almost-empty thresholds and overflow/underflow pulses.
module syn_fifo_ext_module #(
  parameter int unsigned P_DATA_WIDTH = 8,
  parameter int unsigned P_ADDR_DEPTH = 16,
  parameter int unsigned P_FWFT       = 0,
  parameter int unsigned P_AFULL_TH   = 12,
  parameter int unsigned P_AEMPTY_TH  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  syn_fifo_ext_module_if.slave bus
);
  localparam int unsigned AW = $clog2(P_ADDR_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] L_DEPTH  = CW'(P_ADDR_DEPTH);
  localparam logic [CW-1:0] L_AFULL  = CW'(P_AFULL_TH);
  localparam logic [CW-1:0] L_AEMPTY = CW'(P_AEMPTY_TH);

  logic [P_DATA_WIDTH-1:0] mem [P_ADDR_DEPTH];
  logic [CW-1:0]           wr_ptr;
  logic [CW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  logic [CW-1:0]           count_next;
  logic                    wfull_q;
  logic                    afull_q;
  logic                    aempty_q;
  logic                    overflow_q;
  logic                    underflow_q;
  logic                    wr_acc;
  logic                    rd_acc;
  logic                    rempty;

  assign wr_acc = bus.i_wr_en && !wfull_q;

  // Occupancy after this edge: +1 write only, -1 read only, else unchanged
  always_comb begin
    count_next = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Registered count, full/almost flags and error pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count       <= '0;
      wfull_q     <= 1'b0;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count       <= count_next;
      wfull_q     <= (count_next == L_DEPTH);
      afull_q     <= (count_next >= L_AFULL);
      aempty_q    <= (count_next <= L_AEMPTY);
      overflow_q  <= bus.i_wr_en && wfull_q;
      underflow_q <= bus.i_rd_en && rempty;
    end
  end

  // Write pointer advances on every accepted write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
    end else if (wr_acc) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Storage array, never reset; writes suppressed while reset is asserted
  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= bus.i_wdata;
    end
  end

  if (P_FWFT != 0) begin : g_fwft
    logic [CW-1:0]           wr_ptr_d;
    logic [P_DATA_WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    mem_avail;
    logic                    load;

    // Storage is only read past the write pointer as it stood one edge ago,
    // so a word becomes visible two edges after the edge that wrote it.
    assign mem_avail = (rd_ptr != wr_ptr_d);
    assign rd_acc    = bus.i_rd_en && out_valid;
    assign load      = mem_avail && (!out_valid || rd_acc);
    assign rempty    = !out_valid;

    // Output register prefetch: refill when empty or being consumed
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        wr_ptr_d  <= '0;
        rd_ptr    <= '0;
        out_data  <= '0;
        out_valid <= 1'b0;
      end else begin
        wr_ptr_d <= wr_ptr;
        if (load) begin
          out_data  <= mem[rd_ptr[AW-1:0]];
          rd_ptr    <= rd_ptr + 1'b1;
          out_valid <= 1'b1;
        end else if (rd_acc) begin
          out_valid <= 1'b0;
        end
      end
    end

    assign bus.o_rdata  = out_data;
    assign bus.o_rvalid = out_valid;
    assign bus.o_rempty = rempty;
  end else begin : g_std
    logic [CW-1:0]           wr_ptr_next;
    logic [CW-1:0]           rd_ptr_next;
    logic [P_DATA_WIDTH-1:0] rdata_q;
    logic                    rvalid_q;
    logic                    rempty_q;

    assign rd_acc      = bus.i_rd_en && !rempty_q;
    assign wr_ptr_next = wr_acc ? wr_ptr + 1'b1 : wr_ptr;
    assign rd_ptr_next = rd_acc ? rd_ptr + 1'b1 : rd_ptr;
    assign rempty      = rempty_q;

    // Registered read: head word captured at the read edge, valid pulse follows
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        rd_ptr   <= '0;
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
        rempty_q <= 1'b1;
      end else begin
        rd_ptr   <= rd_ptr_next;
        rvalid_q <= rd_acc;
        rempty_q <= (wr_ptr_next == rd_ptr_next);
        if (rd_acc) begin
          rdata_q <= mem[rd_ptr[AW-1:0]];
        end
      end
    end

    assign bus.o_rdata  = rdata_q;
    assign bus.o_rvalid = rvalid_q;
    assign bus.o_rempty = rempty;
  end

  assign bus.o_wfull        = wfull_q;
  assign bus.o_almost_full  = afull_q;
  assign bus.o_overflow     = overflow_q;
  assign bus.o_almost_empty = aempty_q;
  assign bus.o_underflow    = underflow_q;
  assign bus.o_data_count   = count;
endmodule

// File: tb/tb_syn_fifo_ext_module.sv
// Directed-vector bench for syn_fifo_ext_module: standard-mode and FWFT instances.
module tb_syn_fifo_ext_module;
  logic clk = 1'b0;
  logic rst_s;
  logic rst_f;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  syn_fifo_ext_module_if #(.P_DATA_WIDTH(8), .P_ADDR_DEPTH(16)) bs ();
  syn_fifo_ext_module_if #(.P_DATA_WIDTH(8), .P_ADDR_DEPTH(16)) bf ();

  syn_fifo_ext_module #(.P_DATA_WIDTH(8), .P_ADDR_DEPTH(16), .P_FWFT(0),
                        .P_AFULL_TH(12), .P_AEMPTY_TH(2))
    u_std (.i_clk(clk), .i_rst(rst_s), .bus(bs));

  syn_fifo_ext_module #(.P_DATA_WIDTH(8), .P_ADDR_DEPTH(16), .P_FWFT(1),
                        .P_AFULL_TH(12), .P_AEMPTY_TH(2))
    u_fwft (.i_clk(clk), .i_rst(rst_f), .bus(bf));

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] wdata;
    logic [4:0] count;
    logic       wfull;
    logic       rempty;
    logic       afull;
    logic       aempty;
    logic       ovf;
    logic       unf;
    logic       rvalid;
    logic [7:0] rdata;
  } vec_t;

  vec_t tv [37];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [7:0] q[$];
    int mcount;
    logic [7:0] wd;
    logic [7:0] exp_d;
    bit racc;
    bit wacc;
    int len;

    // ---------------- vector table (standard mode) ----------------
    n = 0;
    for (int k = 1; k <= 16; k++) begin
      tv[n] = '{1'b1, 1'b0, 8'(k), 5'(k), (k == 16), 1'b0, (k >= 12), (k <= 2),
                1'b0, 1'b0, 1'b0, 8'h00};
      n++;
    end
    tv[n] = '{1'b1, 1'b0, 8'h11, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}; n++;
    tv[n] = '{1'b1, 1'b1, 8'h12, 5'd15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01}; n++;
    for (int j = 2; j <= 16; j++) begin
      tv[n] = '{1'b0, 1'b1, 8'h00, 5'(16 - j), 1'b0, (j == 16), ((16 - j) >= 12),
                ((16 - j) <= 2), 1'b0, 1'b0, 1'b1, 8'(j)};
      n++;
    end
    tv[n] = '{1'b0, 1'b1, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10}; n++;
    tv[n] = '{1'b1, 1'b1, 8'h55, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10}; n++;
    tv[n] = '{1'b0, 1'b1, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55}; n++;
    tv[n] = '{1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55}; n++;

    bs.i_wr_en = 1'b0; bs.i_rd_en = 1'b0; bs.i_wdata = '0;
    bf.i_wr_en = 1'b0; bf.i_rd_en = 1'b0; bf.i_wdata = '0;
    rst_s = 1'b1;
    rst_f = 1'b1;
    step();
    step();

    // ---------------- reset state ----------------
    chk("rst.count",  bs.o_data_count,   0);
    chk("rst.rempty", bs.o_rempty,       1);
    chk("rst.wfull",  bs.o_wfull,        0);
    chk("rst.aempty", bs.o_almost_empty, 1);
    chk("rst.afull",  bs.o_almost_full,  0);
    chk("rst.rvalid", bs.o_rvalid,       0);
    chk("rst.rdata",  bs.o_rdata,        0);
    chk("rst.ovf",    bs.o_overflow,     0);
    chk("rst.unf",    bs.o_underflow,    0);
    chk("rst_f.rempty", bf.o_rempty,     1);
    chk("rst_f.rvalid", bf.o_rvalid,     0);
    rst_s = 1'b0;
    rst_f = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 37; i++) begin
      bs.i_wr_en = tv[i].wr;
      bs.i_rd_en = tv[i].rd;
      bs.i_wdata = tv[i].wdata;
      step();
      chk($sformatf("v%0d.count", i),  bs.o_data_count,   tv[i].count);
      chk($sformatf("v%0d.wfull", i),  bs.o_wfull,        tv[i].wfull);
      chk($sformatf("v%0d.rempty", i), bs.o_rempty,       tv[i].rempty);
      chk($sformatf("v%0d.afull", i),  bs.o_almost_full,  tv[i].afull);
      chk($sformatf("v%0d.aempty", i), bs.o_almost_empty, tv[i].aempty);
      chk($sformatf("v%0d.ovf", i),    bs.o_overflow,     tv[i].ovf);
      chk($sformatf("v%0d.unf", i),    bs.o_underflow,    tv[i].unf);
      chk($sformatf("v%0d.rvalid", i), bs.o_rvalid,       tv[i].rvalid);
      chk($sformatf("v%0d.rdata", i),  bs.o_rdata,        tv[i].rdata);
    end
    bs.i_wr_en = 1'b0;
    bs.i_rd_en = 1'b0;

    // ---------------- wrap-around bursts with scoreboard ----------------
    mcount = 0;
    for (int b = 0; b < 40; b++) begin
      len = $urandom_range(1, 8);
      for (int c = 0; c < len; c++) begin
        wacc = (b % 2 == 0) && (mcount < 15);
        racc = (b % 2 == 1) && (mcount > 0);
        wd = 8'($urandom);
        bs.i_wr_en = wacc;
        bs.i_rd_en = racc;
        bs.i_wdata = wd;
        step();
        if (wacc) begin
          q.push_back(wd);
          mcount++;
        end
        if (racc) begin
          exp_d = q.pop_front();
          mcount--;
          chk($sformatf("wrap%0d.rdata", b), bs.o_rdata, exp_d);
        end
        chk($sformatf("wrap%0d.rvalid", b), bs.o_rvalid, racc);
        chk($sformatf("wrap%0d.count", b), bs.o_data_count, mcount);
      end
    end
    bs.i_wr_en = 1'b0;
    while (mcount > 0) begin
      bs.i_rd_en = 1'b1;
      step();
      exp_d = q.pop_front();
      mcount--;
      chk("drain.rdata", bs.o_rdata, exp_d);
      chk("drain.count", bs.o_data_count, mcount);
    end
    bs.i_rd_en = 1'b0;
    step();
    chk("drain.rempty", bs.o_rempty, 1);

    // ---------------- reset mid-operation ----------------
    for (int k = 0; k < 7; k++) begin
      bs.i_wr_en = 1'b1;
      bs.i_wdata = 8'(8'hA0 + k);
      step();
    end
    chk("mid.count7", bs.o_data_count, 7);
    bs.i_wr_en = 1'b1;
    bs.i_rd_en = 1'b1;
    rst_s = 1'b1;
    step();
    chk("mid.count",  bs.o_data_count, 0);
    chk("mid.rempty", bs.o_rempty,     1);
    chk("mid.rvalid", bs.o_rvalid,     0);
    chk("mid.ovf",    bs.o_overflow,   0);
    chk("mid.unf",    bs.o_underflow,  0);
    chk("mid.rdata",  bs.o_rdata,      0);
    rst_s = 1'b0;
    bs.i_rd_en = 1'b0;
    bs.i_wdata = 8'h3C;
    step();
    chk("mid.wr.count", bs.o_data_count, 1);
    bs.i_wr_en = 1'b0;
    bs.i_rd_en = 1'b1;
    step();
    chk("mid.rd.rvalid", bs.o_rvalid, 1);
    chk("mid.rd.rdata",  bs.o_rdata,  8'h3C);
    chk("mid.rd.count",  bs.o_data_count, 0);
    bs.i_rd_en = 1'b0;

    // ---------------- FWFT single word latency ----------------
    bf.i_wr_en = 1'b1;
    bf.i_wdata = 8'hA5;
    step();
    bf.i_wr_en = 1'b0;
    chk("fw.e0.count",  bf.o_data_count, 1);
    chk("fw.e0.rvalid", bf.o_rvalid, 0);
    chk("fw.e0.rempty", bf.o_rempty, 1);
    step();
    chk("fw.e1.rvalid", bf.o_rvalid, 0);
    step();
    chk("fw.e2.rvalid", bf.o_rvalid, 1);
    chk("fw.e2.rdata",  bf.o_rdata,  8'hA5);
    chk("fw.e2.rempty", bf.o_rempty, 0);
    chk("fw.e2.count",  bf.o_data_count, 1);
    bf.i_rd_en = 1'b1;
    step();
    chk("fw.rd.rempty", bf.o_rempty, 1);
    chk("fw.rd.rvalid", bf.o_rvalid, 0);
    chk("fw.rd.count",  bf.o_data_count, 0);
    chk("fw.rd.unf",    bf.o_underflow, 0);
    step();
    chk("fw.unf", bf.o_underflow, 1);
    chk("fw.unf.count", bf.o_data_count, 0);
    bf.i_rd_en = 1'b0;
    step();
    chk("fw.unf.clear", bf.o_underflow, 0);

    // ---------------- FWFT streaming ----------------
    for (int k = 0; k < 4; k++) begin
      bf.i_wr_en = 1'b1;
      bf.i_wdata = 8'(8'h10 + k);
      step();
    end
    bf.i_wr_en = 1'b0;
    step();
    step();
    chk("fws.count", bf.o_data_count, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fws%0d.rvalid", k), bf.o_rvalid, 1);
      chk($sformatf("fws%0d.rdata", k),  bf.o_rdata,  8'(8'h10 + k));
      bf.i_rd_en = 1'b1;
      step();
      chk($sformatf("fws%0d.count", k), bf.o_data_count, 3 - k);
    end
    bf.i_rd_en = 1'b0;
    chk("fws.rempty", bf.o_rempty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
